// File: rtl/keypad_if.sv
// Keypad pins and decoded game controls between the scanner (master) and the game core (slave).
interface keypad_if;
   logic [3:0]  key_row;
   logic [3:0]  key_col;
   logic [15:0] keys;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [2:0]  player_pos;
   logic        fire;

   modport master (
      output key_row, keys, key_valid, key_code, player_pos, fire,
      input  key_col
   );

   modport slave (
      input  key_row, keys, key_valid, key_code, player_pos, fire,
      output key_col
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold row drive, per-frame debounce, press-edge decode into
// player movement (LEFT=4, RIGHT=6) and fire (FIRE=5).
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input logic      clk,
   input logic      rst,
   keypad_if.master kp
);
   localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]     DEB      = 4'(DEBOUNCE);

   logic [3:0]    col_meta, col_sync;
   logic [DW-1:0] div;
   logic [1:0]    row;
   logic [3:0]    row_drive;
   logic [15:0]   snapshot, prev_snap, keys_q;
   logic [3:0]    stable_cnt;
   logic          frame_done;
   logic          key_valid_q;
   logic [3:0]    key_code_q;
   logic [2:0]    pos_q;

   logic [3:0]    stable_next;
   logic          update;
   logic [15:0]   new_keys;
   logic [3:0]    low_code;
   logic          move_left, move_right;

   always_comb begin
      stable_next = stable_cnt;
      update      = 1'b0;
      new_keys    = '0;
      low_code    = '0;
      if (snapshot == prev_snap) begin
         if (stable_cnt < DEB) stable_next = stable_cnt + 4'd1;
      end else begin
         stable_next = 4'd1;
      end
      update = frame_done && (stable_next == DEB);
      if (update) new_keys = snapshot & ~keys_q;
      // Descending scan so the lowest set index is the one that sticks.
      for (int i = 15; i >= 0; i--) begin
         if (new_keys[i]) low_code = 4'(i);
      end
      move_left  = new_keys[4] && !new_keys[6];
      move_right = new_keys[6] && !new_keys[4];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_meta    <= '0;
         col_sync    <= '0;
         div         <= '0;
         row         <= 2'd0;
         row_drive   <= 4'b1110;
         snapshot    <= '0;
         prev_snap   <= '0;
         keys_q      <= '0;
         stable_cnt  <= '0;
         frame_done  <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         pos_q       <= 3'd3;
      end else begin
         col_meta    <= kp.key_col;
         col_sync    <= col_meta;
         frame_done  <= 1'b0;
         key_valid_q <= 1'b0;

         if (div == DIV_LAST) begin
            div                      <= '0;
            snapshot[{row, 2'b00} +: 4] <= ~col_sync;
            row                      <= row + 2'd1;
            row_drive                <= ~(4'b0001 << (row + 2'd1));
            frame_done               <= (row == 2'd3);
         end else begin
            div <= div + 1'b1;
         end

         // Frame evaluation runs one clock after the row-3 sample; div is never
         // at its last value here because SCAN_DIV >= 4.
         if (frame_done) begin
            stable_cnt <= stable_next;
            if (snapshot != prev_snap) prev_snap <= snapshot;
         end

         if (update) begin
            keys_q <= snapshot;
            if (|new_keys) begin
               key_valid_q <= 1'b1;
               key_code_q  <= low_code;
            end
            if (move_left && pos_q > 3'd1)       pos_q <= pos_q - 3'd1;
            else if (move_right && pos_q < 3'd6) pos_q <= pos_q + 3'd1;
         end
      end
   end

   assign kp.key_row    = row_drive;
   assign kp.keys       = keys_q;
   assign kp.key_valid  = key_valid_q;
   assign kp.key_code   = key_code_q;
   assign kp.player_pos = pos_q;
   assign kp.fire       = keys_q[5];
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 and a behavioural key matrix.
`timescale 1ns/1ps
module tb_keypad_scanner;
   logic clk;
   logic rst;
   logic [15:0] held;
   int total;
   int bad;
   int pulses;
   int wide;
   logic [3:0] last_code;
   logic kv_prev;
   logic [2:0] exp_q[$];

   keypad_if kp ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a held key pulls its column low while its row is driven low.
   always_comb begin
      logic [3:0] col;
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.key_row[r] && held[r*4+c]) col[c] = 1'b0;
      kp.key_col = col;
   end

   initial begin
      pulses    = 0;
      wide      = 0;
      last_code = '0;
      kv_prev   = 1'b0;
   end

   always @(negedge clk) begin
      if (kp.key_valid) begin
         pulses    = pulses + 1;
         last_code = kp.key_code;
         if (kv_prev) wide = wide + 1;
      end
      kv_prev = kp.key_valid;
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      cycles(3);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      held = '0;
      rst  = 1'b0;
      cycles(3);
      total++;
      if (kp.key_row !== 4'b1110) begin bad++; $display("FAIL reset_row got=%b exp=1110", kp.key_row); end
      total++;
      if (kp.keys !== 16'h0000) begin bad++; $display("FAIL reset_keys got=%h exp=0000", kp.keys); end
      total++;
      if (kp.key_valid !== 1'b0 || kp.key_code !== 4'd0) begin
         bad++; $display("FAIL reset_valid_code got=%b/%0d exp=0/0", kp.key_valid, kp.key_code);
      end
      total++;
      if (kp.player_pos !== 3'd3 || kp.fire !== 1'b0) begin
         bad++; $display("FAIL reset_pos_fire got=%0d/%b exp=3/0", kp.player_pos, kp.fire);
      end
      rst = 1'b1;
   endtask

   task automatic test_scan();
      logic [3:0] exp_row;
      apply_reset();
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         total++;
         if (kp.key_row !== exp_row) begin
            bad++; $display("FAIL scan_row cycle=%0d got=%b exp=%b", k, kp.key_row, exp_row);
         end
         total++;
         if (kp.keys !== 16'h0 || kp.key_valid !== 1'b0 || kp.player_pos !== 3'd3 || kp.fire !== 1'b0) begin
            bad++; $display("FAIL scan_idle cycle=%0d keys=%h valid=%b pos=%0d fire=%b", k, kp.keys,
                            kp.key_valid, kp.player_pos, kp.fire);
         end
      end
   endtask

   task automatic test_left_press();
      int base;
      base = pulses;
      held = 16'h0010;
      cycles(64);
      total++;
      if (pulses - base !== 1 || last_code !== 4'd4) begin
         bad++; $display("FAIL left_pulse got=%0d code=%0d exp=1 code=4", pulses - base, last_code);
      end
      total++;
      if (kp.player_pos !== 3'd2) begin bad++; $display("FAIL left_pos got=%0d exp=2", kp.player_pos); end
      total++;
      if (kp.keys !== 16'h0010) begin bad++; $display("FAIL left_keys got=%h exp=0010", kp.keys); end
      held = 16'h0000;
      cycles(64);
      total++;
      if (kp.keys !== 16'h0000) begin bad++; $display("FAIL left_release_keys got=%h exp=0000", kp.keys); end
      total++;
      if (pulses - base !== 1) begin bad++; $display("FAIL left_release_pulse got=%0d exp=1", pulses - base); end
   endtask

   task automatic test_saturation();
      int base;
      logic [2:0] exp_pos;
      exp_q = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd6};
      apply_reset();
      base = pulses;
      for (int n = 0; n < 5; n++) begin
         exp_pos = exp_q.pop_front();
         held = 16'h0040;
         cycles(64);
         total++;
         if (kp.player_pos !== exp_pos || last_code !== 4'd6) begin
            bad++; $display("FAIL sat_press%0d pos=%0d code=%0d exp pos=%0d code=6", n, kp.player_pos,
                            last_code, exp_pos);
         end
         held = 16'h0000;
         cycles(64);
      end
      total++;
      if (pulses - base !== 5) begin bad++; $display("FAIL sat_pulses got=%0d exp=5", pulses - base); end
   endtask

   task automatic test_bounce();
      int base;
      int fire_seen;
      base      = pulses;
      fire_seen = 0;
      for (int i = 0; i < 4; i++) begin
         held = (i % 2 == 0) ? 16'h0020 : 16'h0000;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (kp.fire) fire_seen++;
         end
      end
      total++;
      if (fire_seen !== 0 || pulses - base !== 0) begin
         bad++; $display("FAIL bounce_quiet fire_cycles=%0d pulses=%0d exp=0/0", fire_seen, pulses - base);
      end
      held = 16'h0020;
      cycles(64);
      total++;
      if (kp.fire !== 1'b1) begin bad++; $display("FAIL bounce_fire got=%b exp=1", kp.fire); end
      total++;
      if (pulses - base !== 1 || last_code !== 4'd5) begin
         bad++; $display("FAIL bounce_pulse got=%0d code=%0d exp=1 code=5", pulses - base, last_code);
      end
      held = 16'h0000;
      cycles(64);
   endtask

   task automatic test_simultaneous();
      int base;
      apply_reset();
      base = pulses;
      held = 16'h0050;
      cycles(64);
      total++;
      if (pulses - base !== 1 || last_code !== 4'd4) begin
         bad++; $display("FAIL simul_pulse got=%0d code=%0d exp=1 code=4", pulses - base, last_code);
      end
      total++;
      if (kp.player_pos !== 3'd3) begin bad++; $display("FAIL simul_pos got=%0d exp=3", kp.player_pos); end
      total++;
      if (kp.keys !== 16'h0050) begin bad++; $display("FAIL simul_keys got=%h exp=0050", kp.keys); end
      held = 16'h0000;
      cycles(64);
   endtask

   task automatic test_reset_mid_scan();
      int waited;
      held   = 16'h0020;
      waited = 0;
      while (kp.fire !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
      total++;
      if (kp.fire !== 1'b1) begin bad++; $display("FAIL midrst_prefire got=%b exp=1 (timeout)", kp.fire); end
      waited = 0;
      while (kp.key_row !== 4'b1011 && waited < 20) begin @(negedge clk); waited++; end
      total++;
      if (kp.key_row !== 4'b1011) begin bad++; $display("FAIL midrst_row_wait got=%b exp=1011", kp.key_row); end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (kp.key_row !== 4'b1110 || kp.fire !== 1'b0 || kp.player_pos !== 3'd3) begin
         bad++; $display("FAIL midrst_state row=%b fire=%b pos=%0d exp 1110/0/3", kp.key_row, kp.fire,
                         kp.player_pos);
      end
      rst = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == 32) begin
            total++;
            if (kp.fire !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b exp=0 at edge 32", kp.fire); end
         end
         if (k == 33) begin
            total++;
            if (kp.fire !== 1'b1) begin bad++; $display("FAIL midrst_refire got=%b exp=1 at edge 33", kp.fire); end
         end
      end
      held = 16'h0000;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      held  = '0;
      rst   = 1'b0;
      test_reset();
      test_scan();
      test_left_press();
      test_saturation();
      test_bounce();
      test_simultaneous();
      test_reset_mid_scan();
      total++;
      if (wide !== 0) begin bad++; $display("FAIL valid_width got=%0d wide pulses exp=0", wide); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one row low at a time and sampling the active-low column returns. It debounces the result per frame and decodes key press edges into game controls. It sits between the board keypad pins and the game core, supplying the player row position and the fire request consumed by the dot-matrix renderer.

## Interface
- SCAN_DIV, 1000: clk cycles each keypad row is driven; legal minimum 4.
- DEBOUNCE, 4: consecutive identical frames required before the debounced key state updates; legal range 1..15.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- key_row  out  4  row drive, active-low, one-cold.
- key_col  in  4  column sense, active-low (pulled up externally), asynchronous.
- keys  out  16  debounced key state; bit r*4+c = 1 while the key at row r, column c is held.
- key_valid  out  1  one-cycle pulse on any new debounced press.
- key_code  out  4  lowest-numbered newly pressed key; valid when key_valid = 1, held otherwise.
- player_pos  out  3  ship centre row, range 1..6.
- fire  out  1  level; equals keys[5].

## Operation
- Key map: code 4 = LEFT, code 5 = FIRE, code 6 = RIGHT. All other codes only produce keys/key_valid/key_code.
- Column synchronizer: 2-FF on key_col, then invert so that 1 = pressed.
- Row scan:
  - div counter runs 0..SCAN_DIV-1.
  - At div = SCAN_DIV-1, the synchronized columns for the current row r are written into snapshot bits [r*4+3 : r*4].
  - At the same edge, r advances (3 wraps to 0) and key_row becomes ~(1<<r_next).
- Frame end: the sample of row 3 completes a frame. On the following clk edge:
  - If snapshot == previous snapshot, stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt = 1 and previous = snapshot.
  - If stable_cnt reaches DEBOUNCE (including the increment in this cycle), then newkeys = snapshot & ~keys, and keys is updated to snapshot.
- Press events, applied in the same cycle keys updates:
  - If newkeys != 0: key_valid = 1 and key_code = index of the lowest set bit.
  - LEFT edge without RIGHT edge: player_pos = max(player_pos-1, 1).
  - RIGHT edge without LEFT edge: player_pos = min(player_pos+1, 6).
  - LEFT and RIGHT edges together: no move.
- Holding a key produces one event only. No auto-repeat.
- Releases update keys but never pulse key_valid.
- Reset values: key_row = 4'b1110, keys = 0, key_valid = 0, key_code = 0, player_pos = 3, fire = 0. All counters, the snapshot and the synchronizers clear.
- Reset asserted mid-frame discards the partial snapshot. Scanning restarts at row 0 with div = 0 on the first clk after rst returns high.

## Timing
- Frame length: 4*SCAN_DIV clocks.
- Settling: each row is driven SCAN_DIV-1 cycles before its sample. The 2-FF synchronizer latency is covered because SCAN_DIV >= 4.
- Press latency: from the first frame that sees the key to the keys update is DEBOUNCE-1 further frames, plus 1 clk after the row-3 sample edge. Add up to one frame of phase uncertainty plus 2 clk of synchronizer delay.
- key_valid is high for exactly one clk per qualifying frame.
- key_code, keys, player_pos and fire all change on the same edge as key_valid.
- A bounce (any snapshot differing from the previous) restarts the count. keys holds its old value meanwhile.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2.

- **Reset and scan.** Release rst.
  - key_row cycles 1110, 1101, 1011, 0111, each for 4 clk, repeating.
  - Outputs stay at reset values with key_col = 1111.
- **LEFT press.** Model holds key_col[0] low whenever key_row = 1101, for 3 frames.
  - key_valid pulses once with key_code = 4.
  - player_pos goes 3 -> 2 and keys = 16'h0010.
  - After release, keys returns to 0 with no pulse.
- **Saturation.** Five separate RIGHT presses from reset.
  - player_pos = 4, 5, 6, 6, 6.
  - key_valid pulses 5 times, each with key_code = 6.
- **Bounce.** FIRE column toggles every frame for 4 frames, then holds for 3 frames.
  - No key_valid and fire = 0 during toggling.
  - After the hold, fire = 1 and key_code = 5 with a single pulse.
- **Simultaneous edges.** LEFT and RIGHT pressed in the same frame.
  - key_valid pulses with key_code = 4.
  - player_pos is unchanged and keys = 16'h0050.
- **Reset mid-scan.** Assert rst while key_row = 1011 with FIRE held.
  - Next clk: key_row = 1110, fire = 0, player_pos = 3.
  - After rst releases, FIRE is re-debounced from scratch and fire returns to 1 after 2 full frames.
